control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have instruction, input, op_code (9), fetched instruction from fetch_unit, already bubble-muxed.
REQ-004 SHALL have zero_flag, input, 1, current data cell == 0, from datapath.
REQ-005 SHALL have pc_src, output, 1; 1 = fetch takes loaded PC next edge.
REQ-006 SHALL have pc_hold, output, 1; 1 = fetch PC not advanced this cycle.
REQ-007 SHALL have bubble, output, 1; 1 = fetch presents op_code 0 (NOP).
REQ-008 SHALL have pc_load, output, 1; 1 = loader captures mem_out byte this cycle.
REQ-009 SHALL have pc_store, output, 1; 1 = storer drives a PC byte onto mem_in this cycle.
REQ-010 SHALL have exec_valid, output, 1, and exec_op, output, op_code (9): instruction issued to datapath.
REQ-011 SHALL have halted, output, 1; sticky halt indicator.

Function
REQ-012 SHALL decode opclass = instruction[8:6]: 000 NOP, 001 ALU, 010 PTR, 011 IO, 100 JUMP, 101 CALL, 110 BRZ, 111 HALT.
REQ-013 SHALL implement states RUN, STORE_LO, STORE_HI, LOAD_LO, LOAD_HI, REDIRECT, HALTED.
REQ-014 In RUN, ALU/PTR/IO SHALL issue same cycle: exec_valid=1, exec_op=instruction; NOP issues exec_valid=0; all other outputs 0.
REQ-015 JUMP in RUN SHALL go LOAD_LO -> LOAD_HI -> REDIRECT -> RUN, one cycle each (4 cycles incl. decode).
REQ-016 LOAD_LO and LOAD_HI SHALL assert pc_load=1, pc_hold=1, bubble=1.
REQ-017 REDIRECT SHALL assert pc_src=1, bubble=1, pc_hold=0; next fetch is loaded PC.
REQ-018 CALL in RUN SHALL go STORE_LO -> STORE_HI -> RUN; both store states assert pc_store=1, pc_hold=1, bubble=1.
REQ-019 BRZ with zero_flag=1 SHALL behave exactly as JUMP; with zero_flag=0 SHALL act as NOP (exec_valid=0, stay RUN).
REQ-020 HALT SHALL enter HALTED; HALTED asserts halted=1, pc_hold=1, bubble=1 until reset.
REQ-021 In any non-RUN state instruction and zero_flag SHALL be ignored and exec_valid=0.
REQ-022 pc_load and pc_store SHALL never be asserted in the same cycle; pc_src SHALL be asserted only in REDIRECT.
REQ-023 Registered state only; outputs SHALL be combinational from state (plus instruction/zero_flag in RUN).

Reset
REQ-024 Reset SHALL force state RUN; with reset high all outputs 0 (exec_op=0, halted=0).
REQ-025 Reset asserted mid-sequence (any load/store/REDIRECT/HALTED state) SHALL abort it; next cycle is RUN, no residual pc_load/pc_store/pc_src.

Configuration
REQ-026 Macro CONTROL_UNIT_STALL_COUNT_EN, when defined, SHALL add output stall_cycles, 16 bits, counting cycles with pc_hold=1, reset 0, saturating at 16'hFFFF.
REQ-027 Without CONTROL_UNIT_STALL_COUNT_EN the port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package definitions SHALL hold op_code, BYTE, PROGRAM_COUNTER, opclass localparams and enum ctrl_state_t.
REQ-029 Combinational classification SHALL be a sub-module op_decoder (instruction -> opclass, is_exec, is_redirect).

Verification
REQ-030 Reset held 2 cycles, then instruction=9'h040 (ALU) -> same cycle exec_valid=1, exec_op=9'h040, pc_hold=0.
REQ-031 instruction=9'h100 (JUMP) -> next 2 cycles pc_load=1,pc_hold=1,bubble=1; 3rd cycle pc_src=1; 4th cycle RUN, exec_valid follows input.
REQ-032 instruction=9'h140 (CALL) -> 2 cycles pc_store=1,pc_hold=1; pc_load=0 throughout; then RUN.
REQ-033 instruction=9'h180 with zero_flag=0 -> exec_valid=0, state RUN; same with zero_flag=1 -> JUMP sequence of REQ-031.
REQ-034 JUMP, then reset asserted during LOAD_HI -> following cycle all outputs 0, state RUN, ALU 9'h041 issues normally.
REQ-035 instruction=9'h1C0 (HALT) for 1 cycle, then ALU for 10 cycles -> halted=1, exec_valid=0 throughout; with macro, stall_cycles=10.

Source files
------------

// File: rtl/control_unit_pkg.sv
// control_unit_pkg -- shared types for the control unit slice.
//   op_code         : 9-bit instruction word, opclass in bits [8:6]
//   BYTE            : 8-bit memory byte
//   PROGRAM_COUNTER : 16-bit program counter (two BYTEs)
//   OPC_*           : opclass encodings
//   ctrl_state_t    : control FSM states
package control_unit_pkg;

  typedef logic [8:0]  op_code;
  typedef logic [7:0]  BYTE;
  typedef logic [15:0] PROGRAM_COUNTER;

  localparam logic [2:0] OPC_NOP  = 3'b000;
  localparam logic [2:0] OPC_ALU  = 3'b001;
  localparam logic [2:0] OPC_PTR  = 3'b010;
  localparam logic [2:0] OPC_IO   = 3'b011;
  localparam logic [2:0] OPC_JUMP = 3'b100;
  localparam logic [2:0] OPC_CALL = 3'b101;
  localparam logic [2:0] OPC_BRZ  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    RUN,
    STORE_LO,
    STORE_HI,
    LOAD_LO,
    LOAD_HI,
    REDIRECT,
    HALTED
  } ctrl_state_t;

endpackage

// File: rtl/control_unit_op_decoder.sv
// op_decoder -- combinational instruction classification.
//   instruction : op_code, fetched instruction
//   opclass     : instruction[8:6]
//   is_exec     : ALU/PTR/IO, issued to the datapath
//   is_redirect : JUMP or BRZ, i.e. a candidate PC redirect (BRZ still
//                 needs zero_flag, qualified by the caller)
module op_decoder
  import control_unit_pkg::*;
(
  input  op_code     instruction,
  output logic [2:0] opclass,
  output logic       is_exec,
  output logic       is_redirect
);

  // Operand bits are not needed for classification.
  logic unused_bits;
  assign unused_bits = ^instruction[5:0];

  always_comb begin
    opclass     = instruction[8:6];
    is_exec     = 1'b0;
    is_redirect = 1'b0;
    case (instruction[8:6])
      OPC_ALU, OPC_PTR, OPC_IO: is_exec     = 1'b1;
      OPC_JUMP, OPC_BRZ:        is_redirect = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit -- sequencing FSM between fetch, PC loader/storer and datapath.
//   clk, reset   : single clock, synchronous active-high reset
//   instruction  : op_code from fetch (already bubble-muxed)
//   zero_flag    : current data cell == 0
//   pc_src       : fetch takes loaded PC on next edge (REDIRECT only)
//   pc_hold      : fetch PC not advanced this cycle
//   bubble       : fetch presents NOP
//   pc_load      : loader captures a mem_out byte
//   pc_store     : storer drives a PC byte onto mem_in
//   exec_valid   : exec_op is issued to the datapath
//   exec_op      : issued instruction
//   halted       : sticky halt indicator
//   stall_cycles : (only with CONTROL_UNIT_STALL_COUNT_EN) saturating
//                  count of cycles with pc_hold=1
module control_unit
  import control_unit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  op_code instruction,
  input  logic   zero_flag,
  output logic   pc_src,
  output logic   pc_hold,
  output logic   bubble,
  output logic   pc_load,
  output logic   pc_store,
  output logic   exec_valid,
  output op_code exec_op,
`ifdef CONTROL_UNIT_STALL_COUNT_EN
  output logic   halted,
  output logic [15:0] stall_cycles
`else
  output logic   halted
`endif
);

  ctrl_state_t state;
  logic [2:0]  opclass;
  logic        is_exec;
  logic        is_redirect;
  logic        take_redirect;

  op_decoder u_dec (
    .instruction (instruction),
    .opclass     (opclass),
    .is_exec     (is_exec),
    .is_redirect (is_redirect)
  );

  // BRZ redirects only when the current cell is zero.
  assign take_redirect = is_redirect && ((opclass == OPC_JUMP) || zero_flag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (take_redirect)             state <= LOAD_LO;
          else if (opclass == OPC_CALL)  state <= STORE_LO;
          else if (opclass == OPC_HALT)  state <= HALTED;
          else                           state <= RUN;
        end
        LOAD_LO:  state <= LOAD_HI;
        LOAD_HI:  state <= REDIRECT;
        REDIRECT: state <= RUN;
        STORE_LO: state <= STORE_HI;
        STORE_HI: state <= RUN;
        HALTED:   state <= HALTED;
        default:  state <= RUN;
      endcase
    end
  end

  // Outputs are gated by reset so a reset landing mid-sequence shows
  // all-zero outputs in that same cycle.
  always_comb begin
    pc_src     = 1'b0;
    pc_hold    = 1'b0;
    bubble     = 1'b0;
    pc_load    = 1'b0;
    pc_store   = 1'b0;
    exec_valid = 1'b0;
    exec_op    = '0;
    halted     = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (is_exec) begin
            exec_valid = 1'b1;
            exec_op    = instruction;
          end
        end
        LOAD_LO, LOAD_HI: begin
          pc_load = 1'b1;
          pc_hold = 1'b1;
          bubble  = 1'b1;
        end
        REDIRECT: begin
          pc_src = 1'b1;
          bubble = 1'b1;
        end
        STORE_LO, STORE_HI: begin
          pc_store = 1'b1;
          pc_hold  = 1'b1;
          bubble   = 1'b1;
        end
        HALTED: begin
          halted  = 1'b1;
          pc_hold = 1'b1;
          bubble  = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CONTROL_UNIT_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (pc_hold && (stall_cycles != STALL_MAX))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] instruction;
  logic       zero_flag;
  logic       pc_src, pc_hold, bubble, pc_load, pc_store, exec_valid, halted;
  logic [8:0] exec_op;
`ifdef CONTROL_UNIT_STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .zero_flag    (zero_flag),
    .pc_src       (pc_src),
    .pc_hold      (pc_hold),
    .bubble       (bubble),
    .pc_load      (pc_load),
    .pc_store     (pc_store),
    .exec_valid   (exec_valid),
    .exec_op      (exec_op),
`ifdef CONTROL_UNIT_STALL_COUNT_EN
    .halted       (halted),
    .stall_cycles (stall_cycles)
`else
    .halted       (halted)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of scheduled control vectors
  // {pc_src, pc_hold, bubble, pc_load, pc_store} still to be played out,
  // plus a sticky halt flag and a stall counter.
  localparam logic [4:0] V_LOAD  = 5'b01110;
  localparam logic [4:0] V_REDIR = 5'b10100;
  localparam logic [4:0] V_STORE = 5'b01101;

  logic [4:0] sched[$];
  bit         m_halt  = 1'b0;
  int         m_stall = 0;

  // Packed {src,hold,bubble,load,store,exec_valid,halted,exec_op[8:0]}
  function automatic logic [15:0] model_out(input logic [8:0] ins, input logic rst);
    int cls;
    cls = int'(ins) / 64;
    if (rst)               return 16'd0;
    if (m_halt)            return {5'b01100, 1'b0, 1'b1, 9'd0};
    if (sched.size() > 0)  return {sched[0], 1'b0, 1'b0, 9'd0};
    if (cls >= 1 && cls <= 3) return {5'b00000, 1'b1, 1'b0, ins};
    return 16'd0;
  endfunction

  task automatic model_step(input logic [8:0] ins, input logic zf, input logic rst,
                            input logic [15:0] expv);
    int cls;
    cls = int'(ins) / 64;
    if (rst) begin
      sched.delete();
      m_halt  = 1'b0;
      m_stall = 0;
    end else begin
      if (expv[14] && m_stall < 65535) m_stall++;
      if (m_halt) begin
      end else if (sched.size() > 0) begin
        void'(sched.pop_front());
      end else begin
        case (cls)
          4: begin sched.push_back(V_LOAD); sched.push_back(V_LOAD); sched.push_back(V_REDIR); end
          5: begin sched.push_back(V_STORE); sched.push_back(V_STORE); end
          6: if (zf) begin sched.push_back(V_LOAD); sched.push_back(V_LOAD); sched.push_back(V_REDIR); end
          7: m_halt = 1'b1;
          default: ;
        endcase
      end
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance model at the edge.
  task automatic step(input string tag, input logic [8:0] ins, input logic zf, input logic rst);
    logic [15:0] obs, expv;
    instruction = ins;
    zero_flag   = zf;
    reset       = rst;
    #2;
    obs  = {pc_src, pc_hold, bubble, pc_load, pc_store, exec_valid, halted, exec_op};
    expv = model_out(ins, rst);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s outputs: got %h expected %h", tag, obs, expv);
    end
    total++;
    assert ((pc_load & pc_store) === 1'b0) else begin
      bad++;
      $error("FAIL %s load_store_overlap: got load=%b store=%b expected not both", tag, pc_load, pc_store);
    end
`ifdef CONTROL_UNIT_STALL_COUNT_EN
    total++;
    assert (stall_cycles === 16'(m_stall)) else begin
      bad++;
      $error("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles, m_stall);
    end
`endif
    @(posedge clk);
    model_step(ins, zf, rst, expv);
    #1;
  endtask

  initial begin
    logic [8:0] ins;
    logic       zf, rst;
    reset = 1'b1; instruction = '0; zero_flag = 1'b0;
    @(posedge clk); #1;

    // Reset held two cycles, then ALU issues immediately.
    step("reset0", 9'h040, 1'b0, 1'b1);
    step("reset1", 9'h040, 1'b0, 1'b1);
    step("alu", 9'h040, 1'b0, 1'b0);

    // JUMP: decode, LOAD_LO, LOAD_HI, REDIRECT, then RUN.
    step("jump_dec", 9'h100, 1'b0, 1'b0);
    step("jump_ll", 9'h055, 1'b1, 1'b0);
    step("jump_lh", 9'h1C0, 1'b0, 1'b0);
    step("jump_rd", 9'h140, 1'b1, 1'b0);
    step("jump_run", 9'h0A3, 1'b0, 1'b0);

    // CALL: two store cycles then RUN.
    step("call_dec", 9'h140, 1'b0, 1'b0);
    step("call_sl", 9'h100, 1'b0, 1'b0);
    step("call_sh", 9'h180, 1'b1, 1'b0);
    step("call_run", 9'h0FF, 1'b0, 1'b0);

    // BRZ not taken, then taken.
    step("brz_nt", 9'h180, 1'b0, 1'b0);
    step("brz_nt_run", 9'h042, 1'b0, 1'b0);
    step("brz_t", 9'h180, 1'b1, 1'b0);
    step("brz_ll", 9'h040, 1'b0, 1'b0);
    step("brz_lh", 9'h040, 1'b0, 1'b0);
    step("brz_rd", 9'h040, 1'b0, 1'b0);
    step("brz_run", 9'h0C7, 1'b0, 1'b0);

    // JUMP aborted by reset in LOAD_HI.
    step("abort_dec", 9'h100, 1'b0, 1'b0);
    step("abort_ll", 9'h000, 1'b0, 1'b0);
    step("abort_rst", 9'h000, 1'b0, 1'b1);
    step("abort_idle", 9'h000, 1'b0, 1'b0);
    step("abort_alu", 9'h041, 1'b0, 1'b0);

    // HALT then ten ALU instructions ignored.
    step("halt_rst", 9'h000, 1'b0, 1'b1);
    step("halt_dec", 9'h1C0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("halted", 9'h040, 1'b1, 1'b0);
`ifdef CONTROL_UNIT_STALL_COUNT_EN
    total++;
    assert (stall_cycles === 16'd10) else begin
      bad++;
      $error("FAIL halt_stall10: got %0d expected 10", stall_cycles);
    end
`endif

    // Randomized traffic against the model.
    step("rand_rst", 9'h000, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      ins = 9'($urandom_range(0, 511));
      if (ins[8:6] == 3'b111 && $urandom_range(0, 9) != 0) ins[8:6] = 3'b001;
      zf  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 29) == 0);
      step("random", ins, zf, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
